// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-domain side of the dual-clock FIFO. Holds the binary/Gray read
// pointers, addresses the dual-port RAM, derives empty / level / almost-empty
// from the write pointer already synchronized into r_clk, and presents data
// first-word-fall-through on a one-entry output register (valid/ready).
//
// Ports
//   r_clk, r_rstn   read clock, async active-low reset
//   rq2_wptr        Gray write pointer, synchronized into r_clk
//   mem_rdata       RAM read data, combinational from raddr
//   r_ready         consumer accepts r_data this cycle
//   raddr           RAM read address (low bits of the binary read pointer)
//   rptr            registered Gray read pointer for the write domain
//   r_valid/r_data  output register and its valid flag
//   r_mem_empty     RAM holds nothing not yet moved to r_data
//   r_level         RAM occupancy, output register excluded
//   r_almost_empty  r_level <= AE_LEVEL
//   r_err           sticky: occupancy above depth seen (corrupt pointer)
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  r_ready,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_mem_empty,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  r_almost_empty,
  output logic                  r_err
);

  localparam int                  PW     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH  = PW'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = PW'(AE_LEVEL);

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rbin_next;
  logic [ADDR_WIDTH:0] rgray_next;
  logic [ADDR_WIDTH:0] wbin_s;
  logic [ADDR_WIDTH:0] lvl;
  logic                load;

  // Move a word from RAM into the output register whenever the register is
  // free or being drained this cycle; r_mem_empty blocks any underflow.
  assign load       = !r_mem_empty && (!r_valid || r_ready);
  assign rbin_next  = rbin + PW'(load);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign raddr      = rbin[ADDR_WIDTH-1:0];

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  // Status is computed against the post-load pointer so it is current on
  // the same edge the load happens.
  assign lvl = wbin_s - rbin_next;

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rbin    <= '0;
      rptr    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      rbin    <= rbin_next;
      rptr    <= rgray_next;
      r_valid <= 1'b1;
      r_data  <= mem_rdata;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_mem_empty    <= 1'b1;
      r_level        <= '0;
      r_almost_empty <= 1'b1;
      r_err          <= 1'b0;
    end else begin
      r_mem_empty    <= (rgray_next == rq2_wptr);
      r_level        <= lvl;
      r_almost_empty <= (lvl <= AE_LVL);
      r_err          <= r_err | (lvl > DEPTH);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          r_clk  = 1'b0;
  logic          r_rstn = 1'b1;
  logic [AW:0]   rq2_wptr = '0;
  logic [DW-1:0] mem_rdata;
  logic          r_ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_mem_empty;
  logic [AW:0]   r_level;
  logic          r_almost_empty;
  logic          r_err;

  logic [DW-1:0] mem [0:15];
  logic [AW:0]   wbin = '0;
  logic [DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AE_LEVEL(2)) dut (
    .r_clk(r_clk), .r_rstn(r_rstn), .rq2_wptr(rq2_wptr), .mem_rdata(mem_rdata),
    .r_ready(r_ready), .raddr(raddr), .rptr(rptr), .r_valid(r_valid), .r_data(r_data),
    .r_mem_empty(r_mem_empty), .r_level(r_level), .r_almost_empty(r_almost_empty),
    .r_err(r_err)
  );

  always #5 r_clk = ~r_clk;
  assign mem_rdata = mem[raddr];

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(negedge r_clk);
  endtask

  // Writer model: store into RAM, advance the synchronized pointer, and
  // remember the word in arrival order.
  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    wbin = wbin + 1'b1;
    rq2_wptr = gray(wbin);
    exp_q.push_back(d);
  endtask

  task automatic test_reset();
    #1 r_rstn = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    repeat (4) begin
      rq2_wptr = 5'($urandom);
      r_ready  = 1'($urandom);
      tick();
    end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", r_valid); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr: got %0h expected 0", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0h expected 0", raddr); end
    checks++; if (r_mem_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", r_mem_empty); end
    checks++; if (r_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %0b expected 1", r_almost_empty); end
    checks++; if (r_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", r_level); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", r_err); end
    rq2_wptr = '0;
    r_ready  = 1'b0;
    wbin     = '0;
    r_rstn   = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    r_ready = 1'b0;
    write_word(8'hA5);
    tick();
    checks++; if (r_mem_empty !== 1'b0) begin errors++; $display("FAIL single_e1_empty: got %0b expected 0", r_mem_empty); end
    checks++; if (r_level !== 5'd1) begin errors++; $display("FAIL single_e1_level: got %0d expected 1", r_level); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid: got %0b expected 0", r_valid); end
    tick();
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL single_e2_valid: got %0b expected 1", r_valid); end
    checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL single_e2_data: got %0h expected a5", r_data); end
    checks++; if (rptr !== 5'b00001) begin errors++; $display("FAIL single_e2_rptr: got %b expected 00001", rptr); end
    checks++; if (r_mem_empty !== 1'b1) begin errors++; $display("FAIL single_e2_empty: got %0b expected 1", r_mem_empty); end
    checks++; if (r_level !== 5'd0) begin errors++; $display("FAIL single_e2_level: got %0d expected 0", r_level); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp;
    r_ready = 1'b0;
    write_word(8'($urandom));
    write_word(8'($urandom));
    repeat (3) tick();
    checks++; if (raddr !== 4'd1) begin errors++; $display("FAIL bp_raddr: got %0d expected 1", raddr); end
    checks++; if (rptr !== 5'b00001) begin errors++; $display("FAIL bp_rptr: got %b expected 00001", rptr); end
    checks++; if (r_level !== 5'd2) begin errors++; $display("FAIL bp_level: got %0d expected 2", r_level); end
    checks++; if (r_almost_empty !== 1'b1) begin errors++; $display("FAIL bp_ae: got %0b expected 1", r_almost_empty); end
    checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL bp_data_stable: got %0h expected a5", r_data); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL bp_stream_valid[%0d]: got %0b expected 1", i, r_valid); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_stream_extra[%0d]: got %0h expected none", i, r_data); end
      else begin
        exp = exp_q.pop_front();
        if (r_data !== exp) begin errors++; $display("FAIL bp_stream_data[%0d]: got %0h expected %0h", i, r_data, exp); end
      end
      r_ready = 1'b1;
      tick();
    end
    r_ready = 1'b0;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid: got %0b expected 0", r_valid); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp;
    logic [AW-1:0] pa;
    logic [AW:0]   pp;
    int popped = 0;
    int wraps  = 0;
    r_ready = 1'b1;
    pa = raddr;
    pp = rptr;
    for (int i = 0; i < 80 && (i < 40 || exp_q.size() != 0); i++) begin
      if (r_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_dup: got %0h expected none", r_data); end
        else begin
          exp = exp_q.pop_front();
          popped++;
          if (r_data !== exp) begin errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", popped, r_data, exp); end
        end
      end
      if (i < 40) write_word(8'($urandom));
      tick();
      if (raddr != pa) begin
        checks++; if (raddr !== pa + 1'b1) begin errors++; $display("FAIL wrap_raddr_step: got %0d expected %0d", raddr, pa + 1'b1); end
        checks++; if ($countones(rptr ^ pp) != 1) begin errors++; $display("FAIL wrap_gray_step: got %b expected one-bit change from %b", rptr, pp); end
        if (pa == 4'd15) begin
          wraps++;
          checks++; if ((rptr ^ pp) !== 5'b10000) begin errors++; $display("FAIL wrap_gray_msb: got %b expected MSB-only change from %b", rptr, pp); end
        end
        pa = raddr;
        pp = rptr;
      end
    end
    r_ready = 1'b0;
    checks++; if (popped != 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", popped); end
    checks++; if (wraps != 2) begin errors++; $display("FAIL wrap_raddr_wraps: got %0d expected 2", wraps); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %0b expected 0", r_valid); end
  endtask

  task automatic test_almost_empty();
    logic [DW-1:0] exp;
    int n;
    r_ready = 1'b0;
    repeat (5) write_word(8'($urandom));
    repeat (3) tick();
    checks++; if (r_level !== 5'd4) begin errors++; $display("FAIL ae_lvl4: got %0d expected 4", r_level); end
    checks++; if (r_almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at4: got %0b expected 0", r_almost_empty); end
    for (int step = 3; step >= 2; step--) begin
      exp = exp_q.pop_front();
      checks++; if (r_data !== exp) begin errors++; $display("FAIL ae_data: got %0h expected %0h", r_data, exp); end
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      checks++; if (r_level !== 5'(step)) begin errors++; $display("FAIL ae_lvl%0d: got %0d expected %0d", step, r_level, step); end
      checks++; if (r_almost_empty !== (step <= 2)) begin errors++; $display("FAIL ae_at%0d: got %0b expected %0b", step, r_almost_empty, step <= 2); end
    end
    n = 0;
    while ((exp_q.size() != 0 || r_valid) && n < 20) begin
      if (r_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ae_drain_extra: got %0h expected none", r_data); end
        else begin
          exp = exp_q.pop_front();
          if (r_data !== exp) begin errors++; $display("FAIL ae_drain_data: got %0h expected %0h", r_data, exp); end
        end
      end
      r_ready = 1'b1;
      tick();
      n++;
    end
    r_ready = 1'b0;
    checks++; if (n >= 20) begin errors++; $display("FAIL ae_drain_timeout: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_error_reset();
    r_rstn = 1'b0;
    r_ready = 1'b0;
    wbin = '0;
    rq2_wptr = '0;
    exp_q.delete();
    tick();
    r_rstn = 1'b1;
    tick();
    rq2_wptr = 5'b11110;
    tick();
    checks++; if (r_level !== 5'd20) begin errors++; $display("FAIL err_level: got %0d expected 20", r_level); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", r_err); end
    rq2_wptr = '0;
    repeat (2) tick();
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", r_err); end
    #2 r_rstn = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b expected 0", r_valid); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL mid_rst_rptr: got %b expected 0", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL mid_rst_raddr: got %0d expected 0", raddr); end
    checks++; if (r_data !== 8'd0) begin errors++; $display("FAIL mid_rst_data: got %0h expected 0", r_data); end
    checks++; if (r_mem_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %0b expected 1", r_mem_empty); end
    checks++; if (r_almost_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_ae: got %0b expected 1", r_almost_empty); end
    checks++; if (r_level !== 5'd0) begin errors++; $display("FAIL mid_rst_level: got %0d expected 0", r_level); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %0b expected 0", r_err); end
    tick();
    r_rstn = 1'b1;
    tick();
    checks++; if (r_mem_empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty: got %0b expected 1", r_mem_empty); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %0b expected 0", r_valid); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_wrap();
    test_almost_empty();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller for the asynchronous dual-clock FIFO. It keeps the binary and Gray read pointers and drives the dual-port RAM read address. It compares the read pointer against the write pointer already synchronized into `r_clk` to produce the empty and level status, and presents data first-word-fall-through on a one-entry output register with a valid/ready handshake. Its Gray read pointer `rptr` feeds the read-to-write synchronizer for full generation on the write side.

## Interface
- `ADDR_WIDTH`, default 4: RAM address bits. Depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `DATA_WIDTH`, default 8: word width.
- `AE_LEVEL`, default 2: `r_almost_empty` asserts when RAM occupancy ≤ AE_LEVEL.
- `r_clk` in 1: read-domain clock.
- `r_rstn` in 1: reset, asynchronous, active-low.
- `rq2_wptr` in ADDR_WIDTH+1: Gray write pointer, already double-synchronized into `r_clk`.
- `mem_rdata` in DATA_WIDTH: RAM read data, combinational from `raddr`.
- `r_ready` in 1: consumer accepts `r_data` this cycle.
- `raddr` out ADDR_WIDTH: RAM read address, equal to `rbin[ADDR_WIDTH-1:0]`.
- `rptr` out ADDR_WIDTH+1: registered Gray read pointer, sent to the write domain.
- `r_valid` out 1: `r_data` holds an unconsumed word.
- `r_data` out DATA_WIDTH: output register.
- `r_mem_empty` out 1: registered; the RAM holds no word not yet moved to the output register.
- `r_level` out ADDR_WIDTH+1: registered RAM occupancy, 0..2^ADDR_WIDTH. Excludes the output register.
- `r_almost_empty` out 1: registered; `r_level` ≤ AE_LEVEL.
- `r_err` out 1: sticky; computed occupancy exceeded 2^ADDR_WIDTH.

## Operation
- Internal state: `rbin` (binary, ADDR_WIDTH+1 bits) and `rptr = rbin ^ (rbin >> 1)`.
- `load = !r_mem_empty && (!r_valid || r_ready)`.
- `rbin_next = rbin + load`, computed modulo 2^(ADDR_WIDTH+1) with natural wrap.
- `rgray_next = rbin_next ^ (rbin_next >> 1)`.
- On `load`:
  - `r_data <= mem_rdata`, `r_valid <= 1`.
  - `rbin <= rbin_next`, `rptr <= rgray_next`.
- Else if `r_valid && r_ready`: `r_valid <= 0`.
- Else: `r_data` and `r_valid` hold.
- Status registers, updated every cycle:
  - `r_mem_empty <= (rgray_next == rq2_wptr)`.
  - `wbin_s` = Gray-to-binary of `rq2_wptr` (prefix XOR, MSB down).
  - `lvl = wbin_s - rbin_next`, ADDR_WIDTH+1 bits, modulo.
  - `r_level <= lvl`.
  - `r_almost_empty <= (lvl <= AE_LEVEL)`.
  - `r_err <= r_err | (lvl > 2^ADDR_WIDTH)`.
- `r_err` clears only on reset. It flags a corrupted pointer (more than one Gray bit changing between samples, or a write-side overflow). No other behaviour changes when `r_err` is set.
- No state machine beyond the output-register valid bit. The RAM-empty state is the registered Gray-pointer compare.
- `r_ready` while `!r_valid` is legal and has no effect.
- Reading never underflows: a load is impossible while `r_mem_empty` = 1.

## Timing
- Reset, asynchronous on `r_rstn` low:
  - `rbin`, `rptr`, `raddr`, `r_data`, `r_level`: 0.
  - `r_valid`, `r_err`: 0.
  - `r_mem_empty`, `r_almost_empty`: 1.
- Reset mid-stream: every output returns to its reset value immediately. An in-flight word is dropped. After release, the first active edge evaluates normally.
- Latency, `rq2_wptr` change to data available:
  - `rq2_wptr` becomes non-equal before edge N.
  - Edge N: `r_mem_empty` falls.
  - Edge N+1: load; `r_valid` = 1 and `rptr` advances.
- Throughput: one word per cycle when `r_ready` = 1 continuously and the RAM is non-empty. Simultaneous consume and load keeps `r_valid` = 1 and replaces `r_data`.
- Backpressure: with `r_valid` = 1 and `r_ready` = 0, `r_data`, `rptr` and `raddr` are stable.
- `rptr` changes by exactly one Gray bit per advance and is registered, so it is glitch-free for the synchronizer.
- Wrap-around: `raddr` goes 2^ADDR_WIDTH−1 → 0 while the `rbin` MSB toggles. Gray 01000 → 11000 at ADDR_WIDTH=4 is the MSB-only change at bin 15 → 16.

## Test plan
- Reset: hold `r_rstn` = 0 with random inputs. Required: `r_valid` = 0, `rptr` = 0, `r_mem_empty` = 1, `r_almost_empty` = 1, `r_level` = 0, `r_err` = 0.
- Single word: `r_ready` = 0, `rq2_wptr` 00000 → 00001, `mem_rdata` = 0xA5.
  - Edge 1: `r_mem_empty` = 0, `r_level` = 1.
  - Edge 2: `r_valid` = 1, `r_data` = 0xA5, `rptr` = 00001, `r_mem_empty` = 1, `r_level` = 0.
- Backpressure: `r_ready` = 0, `rq2_wptr` = 00010 (bin 3).
  - Required: one load only, `rbin` = 1, `r_level` = 2, `r_almost_empty` = 1, `r_data` stable.
  - Raise `r_ready`: one word per cycle, `r_valid` stays 1 through the last word.
- Wrap: stream 40 words with `r_ready` = 1 and the writer model incrementing `rq2_wptr`.
  - Required: in-order data, no drops or duplicates.
  - `raddr` sequence 15 → 0 at bins 15 → 16 and 31 → 32.
  - `rptr` steps differ by one bit.
- Almost-empty: AE_LEVEL = 2, occupancy stepped 4 → 3 → 2. Required: `r_almost_empty` rises exactly when `r_level` = 2.
- Error and mid-stream reset: `rbin` = 0, force `rq2_wptr` = 11110 (bin 20).
  - Required: `r_level` = 20, `r_err` = 1 on the next edge.
  - `r_err` stays 1 after `rq2_wptr` is restored.
  - Pulse `r_rstn`: all reset values, `r_err` = 0.
